// File: rtl/asu_pkg.sv
// asu_pkg: shared opcodes, FSM state encoding and helpers for the add/shift unit.
//   ASU_ADD..ASU_RSV : 3-bit opcode values presented on mode
//   asu_state_e      : 2-bit FSM state encoding (idle / shifting / result held)
//   is_shift()       : true for the five shift/rotate opcodes
package asu_pkg;

  localparam logic [2:0] ASU_ADD = 3'b000;
  localparam logic [2:0] ASU_SUB = 3'b001;
  localparam logic [2:0] ASU_SHL = 3'b010;
  localparam logic [2:0] ASU_SHR = 3'b011;
  localparam logic [2:0] ASU_SRA = 3'b100;
  localparam logic [2:0] ASU_ROL = 3'b101;
  localparam logic [2:0] ASU_ROR = 3'b110;
  localparam logic [2:0] ASU_RSV = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } asu_state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == ASU_SHL) || (op == ASU_SHR) || (op == ASU_SRA) ||
           (op == ASU_ROL) || (op == ASU_ROR);
  endfunction

endpackage

// File: rtl/asu_addsub.sv
// asu_addsub: combinational WIDTH-bit adder/subtractor.
//   a, b  : operands
//   sub   : 0 -> a+b, 1 -> a-b
//   sum   : result modulo 2^WIDTH
//   carry : carry-out for add, borrow (a < b) for subtract
module asu_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  // Subtract as a + ~b + 1; the carry-out is then "no borrow", so invert it.
  always_comb begin
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum   = full[WIDTH-1:0];
    carry = sub ? ~full[WIDTH] : full[WIDTH];
  end

endmodule

// File: rtl/asu_seq.sv
// asu_seq: clocked add/shift unit with valid/ready handshakes on both sides.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operation handshake; mode, x, y captured on accept
//   mode                 : opcode (see asu_pkg)
//   x, y                 : operands; y[SHW-1:0] is the shift amount
//   out_valid / out_ready: result handshake; out and carry held until accepted
//   out, carry           : result and carry/borrow/last-bit-out flag
// Add/sub/reserved finish on the accept edge. Shifts move one bit per edge; the
// accept edge performs the first step so a shift by n is visible n edges later.
module asu_seq
  import asu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry
);

  localparam int unsigned SHW = $clog2(WIDTH);

  asu_state_e       state_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic [SHW-1:0]   cnt_q;
  logic [2:0]       mode_q;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_src;
  logic [WIDTH-1:0] step_res;
  logic             step_c;

  assign amt = y[SHW-1:0];

  asu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a    (x),
    .b    (y),
    .sub  (mode == ASU_SUB),
    .sum  (as_sum),
    .carry(as_carry)
  );

  // One shift step. In idle the step acts on the live inputs (first step at
  // accept); while shifting it acts on the working register.
  always_comb begin
    step_mode = (state_q == StIdle) ? mode : mode_q;
    step_src  = (state_q == StIdle) ? x : out_q;
    step_res  = step_src;
    step_c    = 1'b0;
    case (step_mode)
      ASU_SHL: begin
        step_res = {step_src[WIDTH-2:0], 1'b0};
        step_c   = step_src[WIDTH-1];
      end
      ASU_SHR: begin
        step_res = {1'b0, step_src[WIDTH-1:1]};
        step_c   = step_src[0];
      end
      ASU_SRA: begin
        step_res = {step_src[WIDTH-1], step_src[WIDTH-1:1]};
        step_c   = step_src[0];
      end
      ASU_ROL: step_res = {step_src[WIDTH-2:0], step_src[WIDTH-1]};
      ASU_ROR: step_res = {step_src[0], step_src[WIDTH-1:1]};
      default: begin
        step_res = step_src;
        step_c   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= ASU_ADD;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            mode_q <= mode;
            if ((mode == ASU_ADD) || (mode == ASU_SUB)) begin
              out_q   <= as_sum;
              carry_q <= as_carry;
              state_q <= StDone;
            end else if (is_shift(mode)) begin
              if (amt == '0) begin
                out_q   <= x;
                carry_q <= 1'b0;
                state_q <= StDone;
              end else begin
                out_q   <= step_res;
                carry_q <= step_c;
                cnt_q   <= amt - SHW'(1);
                state_q <= (amt == SHW'(1)) ? StDone : StShift;
              end
            end else begin
              out_q   <= '0;
              carry_q <= 1'b0;
              state_q <= StDone;
            end
          end
        end
        StShift: begin
          out_q   <= step_res;
          carry_q <= step_c;
          cnt_q   <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign out       = out_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_asu_seq.sv
// tb_asu_seq: directed and random checks of asu_seq (WIDTH=8) against an
// arithmetic reference model.
module tb_asu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   mode = '0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic         carry;

  int errors = 0;
  int checks = 0;

  asu_seq #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: result, flag and latency from the opcode definitions.
  function automatic void model(input logic [2:0] m, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic c, output int lat);
    int n;
    int t;
    n   = int'(b[2:0]);
    lat = 1;
    r   = '0;
    c   = 1'b0;
    case (m)
      3'd0: begin t = int'(a) + int'(b); r = t[7:0]; c = t[8]; end
      3'd1: begin t = int'(a) - int'(b); r = t[7:0]; c = (a < b); end
      3'd2: begin r = a << n; c = (n > 0) ? a[8-n] : 1'b0; end
      3'd3: begin r = a >> n; c = (n > 0) ? a[n-1] : 1'b0; end
      3'd4: begin r = $signed(a) >>> n; c = (n > 0) ? a[n-1] : 1'b0; end
      3'd5: r = (a << n) | (a >> (8 - n));
      3'd6: r = (a >> n) | (a << (8 - n));
      default: r = '0;
    endcase
    if (m >= 3'd2 && m <= 3'd6 && n > 0) lat = n;
  endfunction

  // Issue one op from idle, check latency/result, hold backpressure, release.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] er;
    logic         ec;
    int           el;
    int           lat;
    model(m, a, b, er, ec, el);
    in_valid = 1'b1;
    mode = m;
    x = a;
    y = b;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    mode = 3'($urandom);
    x = W'($urandom);
    y = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(el));
    check({tag, ".out"}, 32'(out), 32'(er));
    check({tag, ".carry"}, 32'(carry), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_out"}, 32'(out), 32'(er));
      check({tag, ".hold_carry"}, 32'(carry), 32'(ec));
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".rel_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".rel_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".rel_out_kept"}, 32'(out), 32'(er));
  endtask

  initial begin
    int seen;
    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out", 32'(out), 32'd0);
    check("rst.carry", 32'(carry), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst.in_ready_after", 32'(in_ready), 32'd1);

    // Directed cases.
    run_op("add_f0_20", 3'd0, 8'hF0, 8'h20, 0);
    run_op("sub_05_07", 3'd1, 8'h05, 8'h07, 1);
    run_op("sub_07_05", 3'd1, 8'h07, 8'h05, 0);
    run_op("shl_b1_0b", 3'd2, 8'b1011_0001, 8'h0B, 0);
    run_op("sra_90_4", 3'd4, 8'h90, 8'h04, 0);
    run_op("ror_81_1", 3'd6, 8'h81, 8'h01, 0);
    run_op("rol_81_0", 3'd5, 8'h81, 8'h00, 0);
    run_op("shr_81_7", 3'd3, 8'h81, 8'h07, 0);
    run_op("rsv", 3'd7, 8'hAB, 8'hCD, 0);
    run_op("add_bp5", 3'd0, 8'h01, 8'h01, 5);

    // Pending second op must wait until the edge after out_ready=1.
    in_valid = 1'b1;
    mode = 3'd0;
    x = 8'h01;
    y = 8'h01;
    tick();
    in_valid = 1'b1;
    mode = 3'd1;
    x = 8'h09;
    y = 8'h03;
    for (int i = 0; i < 5; i++) begin
      check("pend.out", 32'(out), 32'h02);
      check("pend.valid", 32'(out_valid), 32'd1);
      check("pend.in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pend.not_taken", 32'(out_valid), 32'd0);
    check("pend.in_ready_now", 32'(in_ready), 32'd1);
    check("pend.out_kept", 32'(out), 32'h02);
    tick();
    in_valid = 1'b0;
    check("pend.second_valid", 32'(out_valid), 32'd1);
    check("pend.second_out", 32'(out), 32'h06);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a shift aborts it.
    in_valid = 1'b1;
    mode = 3'd2;
    x = 8'hFF;
    y = 8'h07;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort.valid", 32'(out_valid), 32'd0);
    check("abort.out", 32'(out), 32'd0);
    check("abort.carry", 32'(carry), 32'd0);
    check("abort.in_ready_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort.in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort.no_result", 32'(seen), 32'd0);

    // Random operations with random backpressure.
    for (int i = 0; i < 150; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), W'($urandom),
             W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
